// File: rtl/ex_mdu_stage.sv
// EX-stage multiply/divide unit with EX/MEM pipeline register.
// Define MDU_FAST_MUL_EN for a single-step combinational multiply instead of the DATA_W-cycle shift-add.
module ex_mdu_stage #(
  parameter int DATA_W    = 32,
  parameter int RD_ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 id_en,
  input  logic                 id_md_start,
  input  logic [2:0]           id_md_op,
  input  logic [DATA_W-1:0]    id_src_0,
  input  logic [DATA_W-1:0]    id_src_1,
  input  logic [DATA_W-1:0]    id_alu_out,
  input  logic                 rs1_fwd_en,
  input  logic                 rs2_fwd_en,
  input  logic [DATA_W-1:0]    mem_fwd_data,
  input  logic [RD_ADDR_W-1:0] id_rd_addr,
  input  logic                 id_gpr_we_,
  output logic                 md_busy,
  output logic                 ex_en,
  output logic                 ex_gpr_we_,
  output logic [RD_ADDR_W-1:0] ex_rd_addr,
  output logic [DATA_W-1:0]    ex_out
);
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [DATA_W-1:0]      a_q, b_q;
  logic [2*DATA_W-1:0]    prod_q;
  logic [2:0]             op_q;
  logic                   res_neg_q, rem_neg_q, div0_q, ovf_q;
  logic [RD_ADDR_W-1:0]   rd_q;
  logic                   we_q;

  logic [DATA_W-1:0]      src0, src1, a_mag, b_mag, result_d;
  logic                   sgn0, sgn1, accept, is_div, div0, ovf;
  logic [DATA_W:0]        mul_sum, div_sh, div_trial;
  logic [2*DATA_W-1:0]    mul_next, div_next, prod_fix;

  always_comb begin
    src0   = rs1_fwd_en ? mem_fwd_data : id_src_0;
    src1   = rs2_fwd_en ? mem_fwd_data : id_src_1;
    is_div = id_md_op[2];
    sgn0   = (id_md_op == 3'b001 || id_md_op == 3'b010 || id_md_op == 3'b100 ||
              id_md_op == 3'b110) && src0[DATA_W-1];
    sgn1   = (id_md_op == 3'b001 || id_md_op == 3'b100 || id_md_op == 3'b110) &&
             src1[DATA_W-1];
    a_mag  = sgn0 ? -src0 : src0;
    b_mag  = sgn1 ? -src1 : src1;
    div0   = (src1 == '0);
    ovf    = !id_md_op[0] && (src0 == {1'b1, {(DATA_W-1){1'b0}}}) && (&src1);
    accept = (state_q == S_IDLE) && id_en && id_md_start && !stall && !flush;
    md_busy = accept || (state_q == S_MUL) || (state_q == S_DIV);
  end

  // One shift-add step (product in prod_q) and one restoring-divide step ({rem, quot} in prod_q)
  always_comb begin
    mul_sum   = {1'b0, prod_q[2*DATA_W-1:DATA_W]} + (prod_q[0] ? {1'b0, a_q} : '0);
    mul_next  = {mul_sum, prod_q[DATA_W-1:1]};
    div_sh    = {prod_q[2*DATA_W-1:DATA_W], prod_q[DATA_W-1]};
    div_trial = div_sh - {1'b0, b_q};
    div_next  = {div_trial[DATA_W] ? div_sh[DATA_W-1:0] : div_trial[DATA_W-1:0],
                 prod_q[DATA_W-2:0], ~div_trial[DATA_W]};
  end

  always_comb begin
    result_d = '0;
    prod_fix = res_neg_q ? -prod_q : prod_q;
    case (op_q)
      3'b000:                 result_d = prod_q[DATA_W-1:0];
      3'b001, 3'b010, 3'b011: result_d = prod_fix[2*DATA_W-1:DATA_W];
      3'b100, 3'b101:         result_d = res_neg_q ? -prod_q[DATA_W-1:0] : prod_q[DATA_W-1:0];
      default:                result_d = rem_neg_q ? -prod_q[2*DATA_W-1:DATA_W]
                                                   : prod_q[2*DATA_W-1:DATA_W];
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;  cnt_q <= '0;  a_q <= '0;  b_q <= '0;  prod_q <= '0;
      op_q <= '0;  res_neg_q <= 1'b0;  rem_neg_q <= 1'b0;  div0_q <= 1'b0;  ovf_q <= 1'b0;
      rd_q <= '0;  we_q <= 1'b1;
      ex_en <= 1'b0;  ex_gpr_we_ <= 1'b1;  ex_rd_addr <= '0;  ex_out <= '0;
    end else if (flush) begin
      state_q <= S_IDLE;  cnt_q <= '0;
      ex_en <= 1'b0;  ex_gpr_we_ <= 1'b1;  ex_rd_addr <= '0;  ex_out <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_q <= id_md_op;  rd_q <= id_rd_addr;  we_q <= id_gpr_we_;
            res_neg_q <= sgn0 ^ sgn1;  rem_neg_q <= sgn0;
            div0_q <= div0;  ovf_q <= ovf;  cnt_q <= '0;
            a_q <= a_mag;  b_q <= b_mag;
            if (is_div) begin
              prod_q  <= {{DATA_W{1'b0}}, a_mag};
              state_q <= S_DIV;
            end else begin
`ifdef MDU_FAST_MUL_EN
              prod_q  <= {{DATA_W{1'b0}}, a_mag} * {{DATA_W{1'b0}}, b_mag};
`else
              prod_q  <= {{DATA_W{1'b0}}, b_mag};
`endif
              state_q <= S_MUL;
            end
            ex_en <= 1'b0;  ex_gpr_we_ <= 1'b1;  ex_rd_addr <= '0;  ex_out <= '0;
          end else if (!stall) begin
            ex_en <= id_en;  ex_gpr_we_ <= id_gpr_we_;
            ex_rd_addr <= id_rd_addr;  ex_out <= id_alu_out;
          end
        end
        S_MUL, S_DIV: begin
          if (state_q == S_MUL) begin
`ifdef MDU_FAST_MUL_EN
            state_q <= S_DONE;
`else
            prod_q <= mul_next;
            cnt_q  <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin cnt_q <= '0; state_q <= S_DONE; end
`endif
          end else if (div0_q) begin
            // quotient all-ones unsigned, remainder magnitude re-signed back to src0
            prod_q <= {a_q, {DATA_W{1'b1}}};  res_neg_q <= 1'b0;  state_q <= S_DONE;
          end else if (ovf_q) begin
            prod_q <= {{DATA_W{1'b0}}, a_q};  state_q <= S_DONE;
          end else begin
            prod_q <= div_next;
            cnt_q  <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin cnt_q <= '0; state_q <= S_DONE; end
          end
          if (!stall) begin
            ex_en <= 1'b0;  ex_gpr_we_ <= 1'b1;  ex_rd_addr <= '0;  ex_out <= '0;
          end
        end
        default: begin
          if (!stall) begin
            ex_en <= 1'b1;  ex_gpr_we_ <= we_q;  ex_rd_addr <= rd_q;  ex_out <= result_d;
            state_q <= S_IDLE;
          end
        end
      endcase
    end
  end
endmodule
